filtered_syncer: RTL and testbench

FILTERED_SYNCER -- requirements
Module: filtered_syncer

---
 rtl/filtered_syncer.sv | 123 ++++++++++++
 tb/tb_filtered_syncer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/filtered_syncer.sv
// ============================================================================
// Module   : filtered_syncer
// Brief    : Per-channel multi-flop synchroniser followed by a stability
//            filter. A level change is accepted only after it has been
//            observed for FILT_CNT consecutive cycles at the synchroniser
//            output. Optional rise/fall pulses accompany each accepted change.
// Options  : define FILTERED_SYNCER_EDGE_EN to build the rise_o/fall_o
//            edge-detect registers; otherwise those ports are tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module filtered_syncer #(
  parameter int                    DLY         = 1,
  parameter int                    DATA_WIDTH  = 1,
  parameter int                    SYNC_STAGES = 2,
  parameter int                    FILT_CNT    = 1,
  parameter logic [DATA_WIDTH-1:0] RST_VAL     = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_unsync_i,
  output logic [DATA_WIDTH-1:0] data_synced_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o,
  output logic                  busy_o
);

  // Counter must hold 0..FILT_CNT-1; at least one bit even when FILT_CNT is 1.
  localparam int                 c_cnt_max  = (FILT_CNT > 2) ? FILT_CNT : 2;
  localparam int                 c_cnt_w    = $clog2(c_cnt_max);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_CNT - 1);

  // DLY is a simulation-only register delay; this implementation updates
  // registers with zero delay, so the value is carried but never applied.
  localparam int                 c_dly_unused = DLY;

  // Synchroniser chain: index 0 captures the raw input, the last index is s[k].
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                  w_sync;

  // Filter state
  logic [c_cnt_w-1:0]    r_cnt [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] r_synced;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_last;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_cnt_nz;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Shift every channel through the synchroniser flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], data_unsync_i};
    end
  end

  // Per-channel decode of "differs from output" and "count has matured".
  assign w_diff = w_sync ^ r_synced;

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_chan
    assign w_last[k]   = (r_cnt[k] == c_cnt_last);
    assign w_cnt_nz[k] = |r_cnt[k];
  end

  // A channel accepts its new level when it still differs on the final count.
  assign w_load = w_diff & w_last;

  // Stability counters: restart whenever s[k] agrees with the output, clear
  // on acceptance, otherwise count consecutive differing cycles.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (rst_i) begin
        r_cnt[k] <= '0;
      end else if (!w_diff[k] || w_last[k]) begin
        r_cnt[k] <= '0;
      end else begin
        r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  // Filtered output register: only accepted channels take the synced value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_synced <= RST_VAL;
    end else begin
      r_synced <= (r_synced & ~w_load) | (w_sync & w_load);
    end
  end

  assign data_synced_o = r_synced;
  assign busy_o        = |w_cnt_nz;

`ifdef FILTERED_SYNCER_EDGE_EN
  logic [DATA_WIDTH-1:0] r_rise;
  logic [DATA_WIDTH-1:0] r_fall;

  // Edge pulses are registered alongside the output load so they coincide
  // with the cycle the new level appears; reset never produces a pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_load & w_sync;
      r_fall <= w_load & ~w_sync;
    end
  end

  assign rise_o = r_rise;
  assign fall_o = r_fall;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_filtered_syncer.sv
// ============================================================================
// Module   : tb_filtered_syncer
// Brief    : Scoreboard bench for filtered_syncer (4 channels, 2 sync stages,
//            filter count 3). Edge-pulse expectations follow whether
//            FILTERED_SYNCER_EDGE_EN is defined for this build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_filtered_syncer;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] data_unsync_i;
  logic [3:0] data_synced_o;
  logic [3:0] rise_o;
  logic [3:0] fall_o;
  logic       busy_o;

  int checks;
  int failures;
  int step_no;

  typedef struct packed {
    int         idx;
    logic [3:0] so;
    logic [3:0] ri;
    logic [3:0] fa;
    logic       bz;
  } exp_t;

  exp_t exp_q[$];

`ifdef FILTERED_SYNCER_EDGE_EN
  localparam bit c_edge_en = 1'b1;
`else
  localparam bit c_edge_en = 1'b0;
`endif

  filtered_syncer #(
    .DLY         (1),
    .DATA_WIDTH  (4),
    .SYNC_STAGES (2),
    .FILT_CNT    (3),
    .RST_VAL     (4'h0)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_unsync_i (data_unsync_i),
    .data_synced_o (data_synced_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input logic rst, input logic [3:0] din,
                      input logic [3:0] so, input logic [3:0] ri,
                      input logic [3:0] fa, input logic bz);
    exp_t e;
    @(negedge clk_i);
    rst_i         = rst;
    data_unsync_i = din;
    e.idx = step_no;
    e.so  = so;
    e.ri  = c_edge_en ? ri : 4'h0;
    e.fa  = c_edge_en ? fa : 4'h0;
    e.bz  = bz;
    exp_q.push_back(e);
    step_no++;
  endtask

  // Monitor: after each edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (data_synced_o !== e.so || rise_o !== e.ri ||
            fall_o !== e.fa || busy_o !== e.bz) begin
          failures++;
          $display("FAIL step%0d: got synced=%h rise=%h fall=%h busy=%b, want synced=%h rise=%h fall=%h busy=%b",
                   e.idx, data_synced_o, rise_o, fall_o, busy_o,
                   e.so, e.ri, e.fa, e.bz);
        end
      end
    end
  end

  initial begin
    checks        = 0;
    failures      = 0;
    step_no       = 0;
    rst_i         = 1'b1;
    data_unsync_i = 4'hF;

    // Reset held two cycles with all inputs high
    step(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // bit0 rises: accepted on the 5th edge with a single rise pulse
    step(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0);
    step(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);

    // Two-cycle glitch on bit1 is rejected
    step(1'b0, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h3, 4'h1, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);

    // Settle at 4'b1000: bit0 falls and bit3 rises together
    step(1'b0, 4'h8, 4'h1, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h8, 4'h1, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h8, 4'h1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h8, 4'h1, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h8, 4'h8, 4'h8, 4'h1, 1'b0);
    step(1'b0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);

    // bit2 rises while bit3 falls on the same edge
    step(1'b0, 4'h4, 4'h8, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h4, 4'h8, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h4, 4'h8, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h4, 4'h8, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h4, 4'h4, 4'h4, 4'h8, 1'b0);
    step(1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);

    // bit0 rising, reset lands mid-count: no pulse, outputs back to zero
    step(1'b0, 4'h5, 4'h4, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h5, 4'h4, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h5, 4'h4, 4'h0, 4'h0, 1'b1);
    step(1'b1, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0);

    // After release the full five-edge latency restarts
    step(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0);
    step(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b1);
    step(1'b0, 4'h5, 4'h5, 4'h5, 4'h0, 1'b0);
    step(1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0);

    // Let the monitor drain the queue within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk_i);
      #2;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
